// File: rtl/boron_key_sched_ctrl_if.sv
// Bundle between the cipher control / BORON key schedule and the round sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface boron_key_sched_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    localparam int unsigned KEY_W = 128;
    localparam int unsigned RK_W  = 64;

    logic              start;
    logic              abort;
    logic [KEY_W-1:0]  key_in;
    logic [RK_W-1:0]   ks_rk;
    logic [KEY_W-1:0]  ks_key;
    logic              ks_select;
    logic [CNT_W-1:0]  ks_count;
    logic              busy;
    logic [RK_W-1:0]   rk_out;
    logic [CNT_W-1:0]  rk_index;
    logic              rk_valid;
    logic              done;

    modport slave (
        input  start, abort, key_in, ks_rk,
        output ks_key, ks_select, ks_count, busy, rk_out, rk_index, rk_valid, done
    );

    modport master (
        output start, abort, key_in, ks_rk,
        input  ks_key, ks_select, ks_count, busy, rk_out, rk_index, rk_valid, done
    );
endinterface

// File: rtl/boron_key_sched_ctrl.sv
// BORON key-schedule round sequencer: loads the master key, steps the schedule
// through NUM_ROUNDS updates and streams each round key out with a done pulse.
module boron_key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS = 25,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    boron_key_sched_ctrl_if.slave bus
);
    localparam int unsigned      KEY_W      = 128;
    localparam int unsigned      RK_W       = 64;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   round_q,    round_d;
    logic [KEY_W-1:0]   ks_key_q,   ks_key_d;
    logic [RK_W-1:0]    rk_out_q,   rk_out_d;
    logic [CNT_W-1:0]   rk_index_q, rk_index_d;
    logic               rk_valid_q, rk_valid_d;
    logic               done_q,     done_d;
    logic               busy_q,     busy_d;
    logic               ks_select_c;
    logic [CNT_W-1:0]   ks_count_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            round_q    <= '0;
            ks_key_q   <= '0;
            rk_out_q   <= '0;
            rk_index_q <= '0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            ks_key_q   <= ks_key_d;
            rk_out_q   <= rk_out_d;
            rk_index_q <= rk_index_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and schedule control
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        ks_key_d    = ks_key_q;
        rk_out_d    = rk_out_q;
        rk_index_d  = rk_index_q;
        rk_valid_d  = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ks_select_c = 1'b0;
        ks_count_c  = '0;

        unique case (state_q)
            ST_IDLE: begin
                // busy lingers through the done cycle, so a start there is dropped
                busy_d = 1'b0;
                if (bus.start && !busy_q) begin
                    ks_key_d = bus.key_in;
                    round_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ks_select_c = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                ks_count_c = (round_q < LAST_ROUND) ? round_q + CNT_W'(1) : '0;
                rk_out_d   = bus.ks_rk;
                rk_index_d = round_q;
                rk_valid_d = 1'b1;
                if (round_q == LAST_ROUND) begin
                    done_d  = 1'b1;
                    round_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    round_d = round_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Abort leaves the last captured key readable but no longer valid
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            round_d    = '0;
            busy_d     = 1'b0;
            rk_out_d   = rk_out_q;
            rk_index_d = rk_index_q;
            rk_valid_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    assign bus.ks_key    = ks_key_q;
    assign bus.ks_select = ks_select_c;
    assign bus.ks_count  = ks_count_c;
    assign bus.busy      = busy_q;
    assign bus.rk_out    = rk_out_q;
    assign bus.rk_index  = rk_index_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_boron_key_sched_ctrl.sv
// Directed bench for boron_key_sched_ctrl with a behavioural BORON key schedule
// attached to the schedule side of the interface.
module tb_boron_key_sched_ctrl;
    localparam int unsigned NR    = 25;
    localparam int unsigned CW    = 5;
    localparam int unsigned NVEC  = 32;
    localparam logic [127:0] KEY_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] KEY_B = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
    localparam logic [127:0] KEY_C = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    boron_key_sched_ctrl_if #(.CNT_W(CW)) bus ();

    boron_key_sched_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hE;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hB;  4'h3: sbox = 4'h1;
            4'h4: sbox = 4'h7;  4'h5: sbox = 4'h9;  4'h6: sbox = 4'hC;  4'h7: sbox = 4'hA;
            4'h8: sbox = 4'hD;  4'h9: sbox = 4'h2;  4'hA: sbox = 4'h0;  4'hB: sbox = 4'hF;
            4'hC: sbox = 4'h8;  4'hD: sbox = 4'h5;  4'hE: sbox = 4'h3;  default: sbox = 4'h6;
        endcase
    endfunction

    function automatic logic [127:0] ks_update(input logic [127:0] k, input logic [4:0] rc);
        logic [127:0] t;
        t        = {k[114:0], k[127:115]};
        t[7:4]   = sbox(t[7:4]);
        t[3:0]   = sbox(t[3:0]);
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    function automatic logic [63:0] rk_at(input logic [127:0] key, input int idx);
        logic [127:0] k;
        k = key;
        for (int i = 1; i <= idx; i++) k = ks_update(k, 5'(i));
        return k[63:0];
    endfunction

    // Behavioural key-schedule register driven by the sequencer
    logic [127:0] sched_q;
    always @(posedge clk) begin
        if (reset)              sched_q <= '0;
        else if (bus.ks_select) sched_q <= bus.ks_key;
        else                    sched_q <= ks_update(sched_q, bus.ks_count);
    end
    assign bus.ks_rk = sched_q[63:0];

    typedef struct {
        logic         start;
        logic [127:0] key;
        logic         busy;
        logic         sel;
        logic [4:0]   cnt;
        logic         valid;
        logic [4:0]   idx;
        logic [63:0]  rk;
        logic         done;
        logic [127:0] ks_key;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_idle(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (!bus.busy) seen = 1'b1;
            next_cycle();
        end
        chk(name, 128'(seen), 128'(1));
    endtask

    initial begin
        int n_valid;
        int n_done;
        int done_cyc;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.key_in = '0;

        for (int n = 0; n < NVEC; n++) begin
            tbl[n].start  = (n == 0) || (n == 5) || (n == 28) || (n == 29);
            tbl[n].key    = (n == 0) ? KEY_A : ((n == 29) ? KEY_C : KEY_B);
            tbl[n].busy   = ((n >= 1) && (n <= 28)) || (n >= 30);
            tbl[n].sel    = (n == 1) || (n == 30);
            tbl[n].cnt    = ((n >= 2) && (n <= 26)) ? 5'(n - 1) : ((n == 31) ? 5'd1 : 5'd0);
            tbl[n].valid  = (n >= 3) && (n <= 28);
            tbl[n].idx    = tbl[n].valid ? 5'(n - 3) : 5'd0;
            tbl[n].rk     = tbl[n].valid ? rk_at(KEY_A, n - 3) : 64'h0;
            tbl[n].done   = (n == 28);
            tbl[n].ks_key = (n == 0) ? 128'h0 : ((n <= 29) ? KEY_A : KEY_C);
        end

        // Reset state
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_busy",  128'(bus.busy),      128'(0));
        chk("rst_sel",   128'(bus.ks_select), 128'(0));
        chk("rst_cnt",   128'(bus.ks_count),  128'(0));
        chk("rst_valid", 128'(bus.rk_valid),  128'(0));
        chk("rst_done",  128'(bus.done),      128'(0));
        chk("rst_rkout", 128'(bus.rk_out),    128'(0));
        chk("rst_ksk",   bus.ks_key,          128'(0));
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Full run with ignored starts at cycles 5 and 28, new run at 29
        for (int n = 0; n < NVEC; n++) begin
            bus.start  = tbl[n].start;
            bus.key_in = tbl[n].key;
            @(negedge clk);
            chk($sformatf("tbl_busy_c%0d", n),  128'(bus.busy),      128'(tbl[n].busy));
            chk($sformatf("tbl_sel_c%0d", n),   128'(bus.ks_select), 128'(tbl[n].sel));
            chk($sformatf("tbl_cnt_c%0d", n),   128'(bus.ks_count),  128'(tbl[n].cnt));
            chk($sformatf("tbl_valid_c%0d", n), 128'(bus.rk_valid),  128'(tbl[n].valid));
            chk($sformatf("tbl_done_c%0d", n),  128'(bus.done),      128'(tbl[n].done));
            chk($sformatf("tbl_kskey_c%0d", n), bus.ks_key,          tbl[n].ks_key);
            if (tbl[n].valid) begin
                chk($sformatf("tbl_idx_c%0d", n), 128'(bus.rk_index), 128'(tbl[n].idx));
                chk($sformatf("tbl_rk_c%0d", n),  128'(bus.rk_out),   128'(tbl[n].rk));
            end
            next_cycle();
        end
        bus.start = 1'b0;
        drain_idle("drain_tbl");

        // All-zero key: known first keys, pulse counts and done timing
        n_valid  = 0;
        n_done   = 0;
        done_cyc = -1;
        for (int n = 0; n <= 31; n++) begin
            bus.start  = (n == 0);
            bus.key_in = '0;
            @(negedge clk);
            if (bus.rk_valid) n_valid++;
            if (n == 3) begin
                chk("z_rk0", 128'(bus.rk_out), 128'(64'h0));
                chk("z_idx0", 128'(bus.rk_index), 128'(0));
            end
            if (n == 4) chk("z_rk1", 128'(bus.rk_out), 128'(64'h0800_0000_0000_00EE));
            if (bus.done) begin
                n_done++;
                done_cyc = n;
                chk("z_done_idx", 128'(bus.rk_index), 128'(NR));
            end
            next_cycle();
        end
        chk("z_valid_cnt", 128'(n_valid),  128'(26));
        chk("z_done_cnt",  128'(n_done),   128'(1));
        chk("z_done_cyc",  128'(done_cyc), 128'(28));

        // Abort at cycle 12
        n_valid = 0;
        n_done  = 0;
        for (int n = 0; n <= 40; n++) begin
            bus.start  = (n == 0);
            bus.abort  = (n == 12);
            bus.key_in = (n == 0) ? KEY_B : KEY_C;
            @(negedge clk);
            if (n == 13) begin
                chk("ab_busy",  128'(bus.busy),     128'(0));
                chk("ab_valid", 128'(bus.rk_valid), 128'(0));
                chk("ab_kskey", bus.ks_key,         KEY_B);
                chk("ab_rkout", 128'(bus.rk_out),   128'(rk_at(KEY_B, 9)));
            end
            if (n >= 13) begin
                if (bus.rk_valid) n_valid++;
                if (bus.busy) n_valid++;
            end
            if (bus.done) n_done++;
            next_cycle();
        end
        bus.abort = 1'b0;
        chk("ab_quiet",   128'(n_valid), 128'(0));
        chk("ab_no_done", 128'(n_done),  128'(0));

        // Abort and start together in IDLE: start wins
        done_cyc = -1;
        for (int n = 0; n <= 40 && done_cyc < 0; n++) begin
            bus.start  = (n == 0);
            bus.abort  = (n == 0);
            bus.key_in = KEY_A;
            @(negedge clk);
            if (n == 1) begin
                chk("as_sel",   128'(bus.ks_select), 128'(1));
                chk("as_busy",  128'(bus.busy),      128'(1));
                chk("as_kskey", bus.ks_key,          KEY_A);
            end
            if (bus.done) begin
                done_cyc = n;
                chk("as_last_rk", 128'(bus.rk_out), 128'(rk_at(KEY_A, NR)));
            end
            next_cycle();
        end
        chk("as_done_cyc", 128'(done_cyc), 128'(28));
        drain_idle("drain_as");

        // Reset mid-run (with start also high), then a fresh start
        for (int n = 0; n <= 15; n++) begin
            bus.start  = (n == 0) || (n == 10) || (n == 11);
            reset      = (n == 10);
            bus.key_in = (n == 11) ? KEY_C : KEY_B;
            @(negedge clk);
            if (n == 11) begin
                chk("mr_busy",  128'(bus.busy),      128'(0));
                chk("mr_sel",   128'(bus.ks_select), 128'(0));
                chk("mr_cnt",   128'(bus.ks_count),  128'(0));
                chk("mr_valid", 128'(bus.rk_valid),  128'(0));
                chk("mr_done",  128'(bus.done),      128'(0));
                chk("mr_rkout", 128'(bus.rk_out),    128'(0));
                chk("mr_idx",   128'(bus.rk_index),  128'(0));
                chk("mr_kskey", bus.ks_key,          128'(0));
            end
            if (n == 12) chk("mr_load", 128'(bus.ks_select), 128'(1));
            if (n == 14) begin
                chk("mr_valid0", 128'(bus.rk_valid), 128'(1));
                chk("mr_idx0",   128'(bus.rk_index), 128'(0));
                chk("mr_rk0",    128'(bus.rk_out),   128'(KEY_C[63:0]));
            end
            next_cycle();
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        drain_idle("drain_mr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boron_key_sched_ctrl.md
Name: boron_key_sched_ctrl

Overview:
Round sequencer for the BORON key-schedule datapath (128-bit key register, 13-bit rotate, two S-boxes on bits [7:0], round-counter XOR on bits [63:59]).
- On a start handshake it latches the 128-bit master key, drives the schedule's load-select and 5-bit round count, and captures each 64-bit round key.
- It presents the captured keys to the cipher round datapath as a registered valid-qualified stream, then signals done.
- It sits between the top-level cipher control and the key-schedule instance.

Parameters:
NUM_ROUNDS, 25, index of the last round key produced; keys RK0..RK_NUM_ROUNDS are emitted. Legal range 1..30.
CNT_W, 5, width of the round count driven to the schedule.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  request a new schedule run; sampled only when busy=0
abort  input  1  synchronous cancel of a run in progress
key_in  input  128  master key; sampled on the start-accept edge
ks_rk  input  64  round key from schedule (low 64 bits of its key register)
ks_key  output  128  latched master key to the schedule's key input
ks_select  output  1  schedule load-select (1 = load ks_key, 0 = update)
ks_count  output  CNT_W  round constant XORed into schedule bits [63:59]
busy  output  1  run in progress
rk_out  output  64  registered round key
rk_index  output  CNT_W  index of rk_out (0..NUM_ROUNDS)
rk_valid  output  1  rk_out/rk_index valid this cycle (single-cycle per key, no backpressure)
done  output  1  one-cycle pulse with the last key

Behaviour:
- Reset: state=IDLE, round=0, ks_key=0, rk_out=0, rk_index=0, rk_valid=0, done=0, busy=0. ks_select=0 and ks_count=0 while in IDLE.
- Reset overrides start and abort in the same cycle.
- FSM states: IDLE, LOAD, RUN. ks_select and ks_count are combinational from state and round.
- IDLE:
  - start=1 at an edge: ks_key<=key_in, round<=0, busy<=1, go to LOAD.
  - start while busy=1 is ignored, not queued.
- LOAD (exactly 1 cycle): ks_select=1, ks_count=0. The schedule loads ks_key at the exiting edge. Next state is RUN.
- RUN with round=r:
  - ks_select=0.
  - ks_count=r+1 if r<NUM_ROUNDS, else 0.
  - ks_rk holds RK_r.
  - At the edge: rk_out<=ks_rk, rk_index<=r, rk_valid<=1.
  - If r<NUM_ROUNDS: round<=r+1, stay in RUN.
  - If r==NUM_ROUNDS: done<=1, go to IDLE.
- rk_valid and done are registered and fall to 0 the cycle after they are set, unless a further key follows.
- busy is set on the start-accept edge and cleared on the edge after done=1, so busy=1 throughout the done cycle.
- Timeline, with start high in cycle 0:
  - LOAD in cycle 1; RUN r=0 in cycle 2.
  - rk_valid/rk_index=0 in cycle 3; rk_index=k in cycle 3+k.
  - Last key and done in cycle 3+NUM_ROUNDS (cycle 28 for the default).
  - busy high in cycles 1..28.
- Back-to-back runs: a start in the done cycle is ignored (busy=1). The earliest accepted start is the cycle after done.
- abort=1 while busy (any state except IDLE):
  - Next edge: state=IDLE, round=0, busy=0, rk_valid=0, done=0.
  - ks_key is retained.
  - A key already registered in rk_out stays readable but is not valid.
- abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Width rules:
  - Round counter is CNT_W bits and never wraps (NUM_ROUNDS ≤ 30 ensures r+1 fits).
  - ks_count is zero-extended; there is no arithmetic on key data.

Test Plan:
- Reset mid-run (assert at cycle 10 of a run) -> next cycle all outputs 0, state IDLE; a fresh start then produces rk_index=0 three cycles later.
- key_in=0, start pulse -> RK0=64'h0 at cycle 3 with rk_index=0; RK1=64'h0800_0000_0000_00EE at cycle 4; 26 rk_valid pulses total; done coincident with rk_index=25 at cycle 28; busy high in cycles 1..28.
- Check ks_select/ks_count sequence for any key -> ks_select=1 only in cycle 1; ks_count = 1,2,...,25,0 in cycles 2..27; keys bit-match a software BORON key-schedule model for key_in=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210.
- start re-asserted at cycles 5 and 28 (done cycle) -> both ignored, ks_key unchanged; start at cycle 29 accepted, LOAD in cycle 30.
- abort at cycle 12 -> cycle 13: busy=0, rk_valid=0, no done pulse ever; ks_key retained.
- abort and start in the same IDLE cycle -> run starts normally.
